// File: rtl/riscy_io_pkg.sv
// Shared IO-space constants and the UART transmitter state encoding.
package riscy_io_pkg;

  localparam int unsigned IO_SELECT_BIT   = 22;
  localparam int unsigned UART_DATA_BIT   = 3;
  localparam int unsigned UART_STATUS_BIT = 4;

  localparam int unsigned STATUS_FULL = 0;
  localparam int unsigned STATUS_BUSY = 1;
  localparam int unsigned STATUS_OVF  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; the caller guarantees
// push only when not full (or popping) and pop only when not empty.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: IO-bus decode, overflow/status register,
// byte FIFO and serialiser with registered tx output.
module io_uart_tx
  import riscy_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [4:0]  WMASK,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned BitCntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e        state_q, state_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        rdata_q, rdata_d;

  logic                io_sel, data_wr, status_rd;
  logic                push, pop, ovf_set, busy, bit_last;
  logic                fifo_full, fifo_empty;
  logic [7:0]          fifo_head;
  logic [FifoCntW-1:0] fifo_count;
  logic [2:0]          status;
  logic                unused_bits;

  assign io_sel    = ADDR[IO_SELECT_BIT];
  assign data_wr   = io_sel & ADDR[UART_DATA_BIT] & WMASK[0];
  assign status_rd = io_sel & ADDR[UART_STATUS_BIT];

  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push    = data_wr & (~fifo_full | pop);
  assign ovf_set = data_wr & fifo_full & ~pop;
  assign busy    = ~fifo_empty | (state_q != StIdle);
  assign ovf_d   = ovf_set | (ovf_q & ~status_rd);

  always_comb begin
    status              = '0;
    status[STATUS_FULL] = fifo_full;
    status[STATUS_BUSY] = busy;
    status[STATUS_OVF]  = ovf_q;
  end

  assign rdata_d = status_rd ? {29'b0, status} : 32'h0;

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .push_i (push),
    .wdata_i(WDATA[7:0]),
    .pop_i  (pop),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign bit_last = (cnt_q == BitCntW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_last) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign tx    = tx_q;
  assign rdata = rdata_q;

  assign unused_bits = ^{ADDR[31:23], ADDR[21:5], ADDR[2:0], WDATA[31:8], WMASK[4:1],
                         fifo_count};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: table of single stores plus hand-written
// sequences for back-to-back frames, overflow, push-on-pop and mid-frame reset.
module tb_io_uart_tx;

  localparam int unsigned Cpb      = 4;
  localparam int unsigned Depth    = 4;
  localparam int unsigned FrameLen = 10 * Cpb;
  localparam logic [31:0] StatusA  = 32'h0040_0010;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [4:0]  WMASK;
  logic [31:0] rdata;
  logic        tx;

  io_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .ADDR (ADDR),
    .WDATA(WDATA),
    .WMASK(WMASK),
    .rdata(rdata),
    .tx   (tx)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] exp_bytes[$];

  // Sample tx mid-cycle; sample k is the value driven after the k-th edge.
  always @(negedge CLK) if (cap_en) cap_q.push_back(tx);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  wmask;
    bit          sends;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [4:0] m);
    ADDR  = a;
    WDATA = d;
    WMASK = m;
    cyc();
    ADDR  = '0;
    WDATA = '0;
    WMASK = '0;
  endtask

  task automatic status_read(input string name, input logic [2:0] exp);
    ADDR  = StatusA;
    WMASK = '0;
    cyc();
    ADDR  = '0;
    check(name, rdata, {29'b0, exp});
  endtask

  function automatic logic [FrameLen-1:0] frame_bits(input logic [7:0] b);
    logic [FrameLen-1:0] f;
    for (int i = 0; i < FrameLen; i++) begin
      int k;
      k = i / Cpb;
      if (k == 0)      f[i] = 1'b0;
      else if (k == 9) f[i] = 1'b1;
      else             f[i] = b[k-1];
    end
    return f;
  endfunction

  task automatic start_capture();
    cap_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic run_capture(input int len);
    int budget;
    budget = len + 10;
    while (cap_q.size() < len && budget > 0) begin
      cyc();
      budget--;
    end
    cap_en = 1'b0;
  endtask

  // Expect two idle samples, n contiguous frames of exp_bytes, then tail idle samples.
  task automatic check_stream(input string name, input int n, input int tail);
    int exp_len;
    int bad_idle;
    exp_len  = 2 + n * FrameLen + tail;
    bad_idle = 0;
    check({name, " length"}, cap_q.size(), exp_len);
    if (cap_q.size() == exp_len) begin
      for (int i = 0; i < 2; i++) if (cap_q[i] !== 1'b1) bad_idle++;
      for (int f = 0; f < n; f++) begin
        logic [FrameLen-1:0] act;
        for (int i = 0; i < FrameLen; i++) act[i] = cap_q[2 + f * FrameLen + i];
        check($sformatf("%s frame%0d", name, f), act, frame_bits(exp_bytes[f]));
      end
      for (int i = 0; i < tail; i++) if (cap_q[2 + n * FrameLen + i] !== 1'b1) bad_idle++;
      check({name, " idle bits"}, bad_idle, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0040_0008, 32'h0000_00A5, 5'b00001, 1'b1, 8'hA5};
    vecs[1] = '{32'h0040_0008, 32'h1234_5678, 5'b11111, 1'b1, 8'h78};
    vecs[2] = '{32'h0000_0008, 32'h0000_00C3, 5'b11111, 1'b0, 8'h00};
    vecs[3] = '{32'h0040_0018, 32'h0000_AB3C, 5'b01111, 1'b1, 8'h3C};
    vecs[4] = '{32'h0040_0010, 32'h0000_0055, 5'b00001, 1'b0, 8'h00};
    vecs[5] = '{32'h0040_0008, 32'h0000_0066, 5'b00000, 1'b0, 8'h00};

    RESET = 1'b1;
    ADDR  = '0;
    WDATA = '0;
    WMASK = '0;
    repeat (3) cyc();
    RESET = 1'b0;
    check("reset tx", tx, 1'b1);
    check("reset rdata", rdata, 32'h0);

    // Idle: STATUS polled continuously reads zero, line stays high.
    ADDR = StatusA;
    for (int c = 0; c < 100; c++) begin
      cyc();
      check($sformatf("idle status c%0d", c), rdata, 32'h0);
      check($sformatf("idle tx c%0d", c), tx, 1'b1);
    end
    ADDR = '0;
    cyc();

    // Single stores: frame shape, latency, busy mid-frame, idle after.
    foreach (vecs[v]) begin
      bus_write(vecs[v].addr, vecs[v].wdata, vecs[v].wmask);
      start_capture();
      repeat (9) cyc();
      status_read($sformatf("vec%0d busy", v), vecs[v].sends ? 3'b010 : 3'b000);
      run_capture(2 + FrameLen + 4);
      exp_bytes.delete();
      if (vecs[v].sends) begin
        exp_bytes.push_back(vecs[v].exp_byte);
        check_stream($sformatf("vec%0d", v), 1, 4);
      end else begin
        check_stream($sformatf("vec%0d", v), 0, FrameLen + 4);
      end
      status_read($sformatf("vec%0d done", v), 3'b000);
    end

    // Six consecutive stores: five fit (first pop frees a slot), sixth overflows.
    exp_bytes.delete();
    for (int b = 1; b <= 6; b++) begin
      bus_write(32'h0040_0008, 32'(b), 5'b00001);
      if (b == 1) start_capture();
      if (b <= 5) exp_bytes.push_back(8'(b));
    end
    status_read("ovf set", 3'b111);
    status_read("ovf cleared", 3'b011);
    run_capture(2 + 5 * FrameLen + 4);
    check_stream("burst", 5, 4);
    status_read("burst done", 3'b000);

    // Fill the FIFO, then push on the exact edge of the end-of-STOP pop.
    exp_bytes.delete();
    for (int b = 0; b < 5; b++) begin
      bus_write(32'h0040_0008, 32'h10 + 32'(b), 5'b00001);
      if (b == 0) start_capture();
      exp_bytes.push_back(8'h10 + 8'(b));
    end
    status_read("full", 3'b011);
    repeat (35) cyc();
    bus_write(32'h0040_0008, 32'h15, 5'b00001);
    exp_bytes.push_back(8'h15);
    status_read("push on pop", 3'b011);
    run_capture(2 + 6 * FrameLen + 4);
    check_stream("push on pop", 6, 4);
    status_read("push on pop done", 3'b000);

    // Reset mid-DATA of 8'hFF with two bytes queued.
    bus_write(32'h0040_0008, 32'hFF, 5'b00001);
    bus_write(32'h0040_0008, 32'h01, 5'b00001);
    bus_write(32'h0040_0008, 32'h02, 5'b00001);
    repeat (13) cyc();
    RESET = 1'b1;
    ADDR  = StatusA;
    cyc();
    RESET = 1'b0;
    ADDR  = '0;
    check("mid reset tx", tx, 1'b1);
    check("mid reset rdata", rdata, 32'h0);
    status_read("mid reset status", 3'b000);
    start_capture();
    run_capture(100);
    begin
      int lows;
      lows = 0;
      foreach (cap_q[i]) if (cap_q[i] !== 1'b1) lows++;
      check("post reset low samples", lows, 0);
    end
    check("post reset samples", cap_q.size(), 100);
    status_read("post reset status", 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
